// File: rtl/memory_stage_if.sv
// EX/MEM -> memory stage -> MEM/WB signal bundle.
// master: EX/MEM side (drives the request, receives MEM/WB payload).
// slave : the memory stage itself.
interface memory_stage_if;
  logic [31:0] Data;
  logic [31:0] Address;
  logic [2:0]  WB_Address;
  logic        MR;
  logic        MW;
  logic        WB;
  logic        JWSP;
  logic        Stack_PC;
  logic        Stack_Flags;
  logic [2:0]  Final_Flags;
  logic        Stall;
  logic        WB_Out;
  logic        MR_Out;
  logic [2:0]  WB_Address_Out;
  logic [15:0] ALU_Data_Out;
  logic [15:0] Mem_Data_Out;
  logic        Flags_Restore;
  logic [2:0]  Flags_From_Memory;
  logic        PC_Load;
  logic [31:0] PC_From_Memory;

  modport master (
    output Data, Address, WB_Address, MR, MW, WB, JWSP, Stack_PC, Stack_Flags, Final_Flags,
    input  Stall, WB_Out, MR_Out, WB_Address_Out, ALU_Data_Out, Mem_Data_Out,
           Flags_Restore, Flags_From_Memory, PC_Load, PC_From_Memory
  );

  modport slave (
    input  Data, Address, WB_Address, MR, MW, WB, JWSP, Stack_PC, Stack_Flags, Final_Flags,
    output Stall, WB_Out, MR_Out, WB_Address_Out, ALU_Data_Out, Mem_Data_Out,
           Flags_Restore, Flags_From_Memory, PC_Load, PC_From_Memory
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: owns the 16-bit data/stack RAM, performs single-cycle loads/stores
// and flag push/pop, two-cycle 32-bit PC push/pop, and registers the MEM/WB payload.
module memory_stage #(
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic           clk,
  input  logic           rst,
  memory_stage_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t state_q, state_d;

  logic [15:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  start_pc;
  logic [15:0]           rd_lo;
  logic [15:0]           rd_up;

  // Transfer context captured in the first cycle of a PC push/pop
  logic [ADDR_WIDTH-1:0] a_q;
  logic [15:0]           data_lo_q;
  logic [15:0]           lo_q;
  logic                  mr_q, mw_q, jwsp_q, wb_q;
  logic [2:0]            wba_q;

  // RAM write port
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [15:0]           mem_wdata;

  // MEM/WB registers
  logic        wb_out_q, wb_out_d;
  logic        mr_out_q, mr_out_d;
  logic [2:0]  wba_out_q, wba_out_d;
  logic [15:0] alu_q, alu_d;
  logic [15:0] mdo_q, mdo_d;
  logic        fr_q, fr_d;
  logic [2:0]  ffm_q, ffm_d;
  logic        pcl_q, pcl_d;
  logic [31:0] pcfm_q, pcfm_d;

  logic unused_addr_hi;

  assign idx            = bus.Address[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^bus.Address[31:ADDR_WIDTH];
  assign start_pc       = bus.Stack_PC & (bus.MR | bus.MW);
  assign bus.Stall      = (state_q == IDLE) & start_pc;

  // Read ports: current index, and the word above the latched index for a pop
  assign rd_lo = mem[idx];
  assign rd_up = mem[a_q + ADDR_ONE];

  // Next-state logic: a PC transfer always spends exactly one extra cycle in SECOND
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_pc) state_d = SECOND;
      SECOND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM write selection: upper PC half / flags / data in IDLE, lower PC half one below in SECOND
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = bus.Data[15:0];
    if (state_q == IDLE) begin
      if (bus.MW) begin
        mem_we = 1'b1;
        if (bus.Stack_PC)         mem_wdata = bus.Data[31:16];
        else if (bus.Stack_Flags) mem_wdata = {13'b0, bus.Final_Flags};
      end
    end else if (mw_q) begin
      mem_we    = 1'b1;
      mem_waddr = a_q - ADDR_ONE;
      mem_wdata = data_lo_q;
    end
  end

  // MEM/WB payload: bubble while stalling, latched context in SECOND, else follow inputs
  always_comb begin
    wb_out_d  = bus.WB;
    mr_out_d  = bus.MR;
    wba_out_d = bus.WB_Address;
    alu_d     = bus.Data[15:0];
    mdo_d     = mdo_q;
    fr_d      = 1'b0;
    ffm_d     = ffm_q;
    pcl_d     = 1'b0;
    pcfm_d    = pcfm_q;
    if (state_q == IDLE) begin
      if (start_pc) begin
        wb_out_d  = 1'b0;
        mr_out_d  = 1'b0;
        wba_out_d = '0;
        alu_d     = '0;
      end else if (bus.MR) begin
        mdo_d = rd_lo;
        if (bus.Stack_Flags) begin
          fr_d  = 1'b1;
          ffm_d = rd_lo[2:0];
        end
      end
    end else begin
      wb_out_d  = wb_q;
      mr_out_d  = mr_q;
      wba_out_d = wba_q;
      alu_d     = data_lo_q;
      if (mr_q) begin
        pcfm_d = {rd_up, lo_q};
        pcl_d  = jwsp_q;
      end
    end
  end

  // RAM array: not cleared by reset, and no write lands while reset is asserted
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // State, transfer context and MEM/WB registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      data_lo_q <= '0;
      lo_q      <= '0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      jwsp_q    <= 1'b0;
      wb_q      <= 1'b0;
      wba_q     <= '0;
      wb_out_q  <= 1'b0;
      mr_out_q  <= 1'b0;
      wba_out_q <= '0;
      alu_q     <= '0;
      mdo_q     <= '0;
      fr_q      <= 1'b0;
      ffm_q     <= '0;
      pcl_q     <= 1'b0;
      pcfm_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start_pc) begin
        a_q       <= idx;
        data_lo_q <= bus.Data[15:0];
        lo_q      <= rd_lo;
        mr_q      <= bus.MR;
        mw_q      <= bus.MW;
        jwsp_q    <= bus.JWSP;
        wb_q      <= bus.WB;
        wba_q     <= bus.WB_Address;
      end
      wb_out_q  <= wb_out_d;
      mr_out_q  <= mr_out_d;
      wba_out_q <= wba_out_d;
      alu_q     <= alu_d;
      mdo_q     <= mdo_d;
      fr_q      <= fr_d;
      ffm_q     <= ffm_d;
      pcl_q     <= pcl_d;
      pcfm_q    <= pcfm_d;
    end
  end

  assign bus.WB_Out            = wb_out_q;
  assign bus.MR_Out            = mr_out_q;
  assign bus.WB_Address_Out    = wba_out_q;
  assign bus.ALU_Data_Out      = alu_q;
  assign bus.Mem_Data_Out      = mdo_q;
  assign bus.Flags_Restore     = fr_q;
  assign bus.Flags_From_Memory = ffm_q;
  assign bus.PC_Load           = pcl_q;
  assign bus.PC_From_Memory    = pcfm_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// operation mix against a word-array reference model.
module tb_memory_stage;

  localparam int unsigned DEPTH = 2048;
  localparam int unsigned MASK  = DEPTH - 1;

  logic clk;
  logic rst;

  memory_stage_if bus ();

  memory_stage #(.ADDR_WIDTH(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [15:0] ref_mem   [DEPTH];
  bit          ref_valid [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_inputs(input bit mr, input bit mw, input bit wb, input bit sp,
                            input bit sf, input bit jwsp, input int unsigned a,
                            input logic [31:0] d, input logic [2:0] wba, input logic [2:0] ff);
    bus.MR          = mr;
    bus.MW          = mw;
    bus.WB          = wb;
    bus.Stack_PC    = sp;
    bus.Stack_Flags = sf;
    bus.JWSP        = jwsp;
    bus.Address     = a;
    bus.Data        = d;
    bus.WB_Address  = wba;
    bus.Final_Flags = ff;
  endtask

  task automatic idle_inputs();
    set_inputs(0, 0, 0, 0, 0, 0, 0, 32'h0, 3'd0, 3'd0);
  endtask

  // Single-cycle access; called at a negedge, returns at the negedge after the capture edge
  task automatic single(input bit mr, input bit mw, input bit wb, input bit sf,
                        input int unsigned a, input logic [31:0] d,
                        input logic [2:0] wba, input logic [2:0] ff);
    logic [15:0] pre;
    bit          pre_v;
    pre   = ref_mem[a];
    pre_v = ref_valid[a];
    set_inputs(mr, mw, wb, 0, sf, 0, a, d, wba, ff);
    #1 check_eq("single_stall", bus.Stall, 1'b0);
    @(posedge clk);
    if (mw) begin
      ref_mem[a]   = sf ? {13'b0, ff} : d[15:0];
      ref_valid[a] = 1'b1;
    end
    @(negedge clk);
    check_eq("single_wb",     bus.WB_Out, wb);
    check_eq("single_mr",     bus.MR_Out, mr);
    check_eq("single_wba",    bus.WB_Address_Out, wba);
    check_eq("single_alu",    bus.ALU_Data_Out, d[15:0]);
    check_eq("single_fr",     bus.Flags_Restore, mr & sf);
    check_eq("single_pcload", bus.PC_Load, 1'b0);
    if (mr && pre_v) check_eq("single_mdo", bus.Mem_Data_Out, pre);
    if (mr && sf && pre_v) check_eq("single_ffm", bus.Flags_From_Memory, pre[2:0]);
  endtask

  // Two-cycle PC push (pop=0) or pop (pop=1)
  task automatic pc_op(input bit pop, input bit jwsp, input bit wb, input int unsigned a,
                       input logic [31:0] d, input logic [2:0] wba);
    logic [31:0] exp_pc;
    bit          exp_v;
    exp_v  = ref_valid[a] && ref_valid[(a + 1) & MASK];
    exp_pc = {ref_mem[(a + 1) & MASK], ref_mem[a]};
    set_inputs(pop, !pop, wb, 1, 0, jwsp, a, d, wba, 3'd0);
    #1 check_eq("pc_stall_first", bus.Stall, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_eq("pc_stall_second", bus.Stall, 1'b0);
    check_eq("pc_bubble_wb",    bus.WB_Out, 1'b0);
    check_eq("pc_bubble_mr",    bus.MR_Out, 1'b0);
    check_eq("pc_bubble_pcl",   bus.PC_Load, 1'b0);
    check_eq("pc_bubble_fr",    bus.Flags_Restore, 1'b0);
    @(posedge clk);
    if (!pop) begin
      ref_mem[a]                = d[31:16];
      ref_valid[a]              = 1'b1;
      ref_mem[(a - 1) & MASK]   = d[15:0];
      ref_valid[(a - 1) & MASK] = 1'b1;
    end
    @(negedge clk);
    check_eq("pc_wb",     bus.WB_Out, wb);
    check_eq("pc_mr",     bus.MR_Out, pop);
    check_eq("pc_wba",    bus.WB_Address_Out, wba);
    check_eq("pc_alu",    bus.ALU_Data_Out, d[15:0]);
    check_eq("pc_pcload", bus.PC_Load, pop & jwsp);
    check_eq("pc_fr",     bus.Flags_Restore, 1'b0);
    if (pop && exp_v) check_eq("pc_value", bus.PC_From_Memory, exp_pc);
  endtask

  task automatic idle_cycle();
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_wb",  bus.WB_Out, 1'b0);
    check_eq("idle_pcl", bus.PC_Load, 1'b0);
    check_eq("idle_fr",  bus.Flags_Restore, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wb"},   bus.WB_Out, 1'b0);
    check_eq({tag, "_mr"},   bus.MR_Out, 1'b0);
    check_eq({tag, "_wba"},  bus.WB_Address_Out, 3'd0);
    check_eq({tag, "_alu"},  bus.ALU_Data_Out, 16'h0);
    check_eq({tag, "_mdo"},  bus.Mem_Data_Out, 16'h0);
    check_eq({tag, "_fr"},   bus.Flags_Restore, 1'b0);
    check_eq({tag, "_ffm"},  bus.Flags_From_Memory, 3'd0);
    check_eq({tag, "_pcl"},  bus.PC_Load, 1'b0);
    check_eq({tag, "_pcfm"}, bus.PC_From_Memory, 32'h0);
  endtask

  function automatic int unsigned pick_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 12'h7FE;
      4: return 12'h7FF;
      5: return 40 + $urandom_range(0, 3);
      default: return $urandom_range(0, MASK);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = 16'h0;
      ref_valid[i] = 1'b0;
    end
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check_eq("reset_stall", bus.Stall, 1'b0);
    rst = 1'b0;

    // Store then load
    single(0, 1, 0, 0, 5, 32'h0000_00AB, 3'd0, 3'd0);
    single(1, 0, 1, 0, 5, 32'h0, 3'd3, 3'd0);
    check_eq("t1_mdo", bus.Mem_Data_Out, 16'h00AB);

    // PC push at the top, pop back with JWSP
    pc_op(0, 0, 0, 12'h7FF, 32'h1234_5678, 3'd0);
    single(1, 0, 1, 0, 12'h7FF, 32'h0, 3'd1, 3'd0);
    check_eq("t2_hi", bus.Mem_Data_Out, 16'h1234);
    single(1, 0, 1, 0, 12'h7FE, 32'h0, 3'd1, 3'd0);
    check_eq("t2_lo", bus.Mem_Data_Out, 16'h5678);
    pc_op(1, 1, 0, 12'h7FE, 32'h0, 3'd0);
    check_eq("t3_pc", bus.PC_From_Memory, 32'h1234_5678);
    idle_cycle();

    // Wrap-around push/pop
    pc_op(0, 0, 0, 0, 32'hA5A5_3C3C, 3'd0);
    pc_op(1, 1, 1, 12'h7FF, 32'h0, 3'd6);
    check_eq("t4_pc", bus.PC_From_Memory, 32'hA5A5_3C3C);
    idle_cycle();

    // Flags push/pop
    single(0, 1, 0, 1, 10, 32'hFFFF_FFF0, 3'd0, 3'b101);
    single(1, 0, 0, 0, 10, 32'h0, 3'd0, 3'd0);
    check_eq("t5_word", bus.Mem_Data_Out, 16'h0005);
    single(1, 0, 0, 1, 10, 32'h0, 3'd0, 3'd0);
    check_eq("t5_ffm", bus.Flags_From_Memory, 3'b101);
    check_eq("t5_fr",  bus.Flags_Restore, 1'b1);
    idle_cycle();

    // Reset in the second cycle of a push aborts the lower-half write
    single(0, 1, 0, 0, 19, 32'h0000_BEEF, 3'd0, 3'd0);
    set_inputs(0, 1, 1, 1, 0, 0, 20, 32'hCAFE_1111, 3'd2, 3'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check_all_zero("midrst");
    idle_inputs();
    #1 check_eq("midrst_stall", bus.Stall, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[20]   = 16'hCAFE;
    ref_valid[20] = 1'b1;
    single(1, 0, 1, 0, 19, 32'h0, 3'd4, 3'd0);
    check_eq("t6_lo_kept", bus.Mem_Data_Out, 16'hBEEF);
    single(1, 0, 1, 0, 20, 32'h0, 3'd4, 3'd0);
    check_eq("t6_hi", bus.Mem_Data_Out, 16'hCAFE);

    // Randomized operation mix
    for (int n = 0; n < 300; n++) begin
      int unsigned     kind;
      int unsigned     a;
      logic [31:0]     d;
      logic [2:0]      wba;
      logic [2:0]      ff;
      bit              wb;
      kind = $urandom_range(0, 6);
      a    = pick_addr();
      d    = $urandom;
      wba  = 3'($urandom_range(0, 7));
      ff   = 3'($urandom_range(0, 7));
      wb   = 1'($urandom_range(0, 1));
      case (kind)
        0: single(0, 1, wb, 0, a, d, wba, ff);
        1: single(1, 0, wb, 0, a, d, wba, ff);
        2: single(0, 1, wb, 1, a, d, wba, ff);
        3: single(1, 0, wb, 1, a, d, wba, ff);
        4: pc_op(0, 0, wb, a, d, wba);
        5: pc_op(1, 1'($urandom_range(0, 1)), wb, a, d, wba);
        default: idle_cycle();
      endcase
    end

    idle_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
